fifo_buffer: RTL and testbench
==============================

// Module: fifo_buffer
// PURPOSE
// - Synchronous first-word-fall-through (FWFT) FIFO. It is the input buffer of stream
//   modules (e.g. the WRITE block) that decouple an upstream valid-only producer from
//   a downstream consumer.
// - The head word is always presented on data_read with no read latency.
// - The consumer pops the head word with next_read.
// PARAMETERS
// - NUM_SLOTS      4  number of storage entries (>=2; need not be a power of two)
// - LOG_NUM_SLOTS  2  pointer width, ceil(log2(NUM_SLOTS))
// - DATA_WIDTH     8  width of each stored word
// PORTS
// - clk          in   1              clock; all state updates on the rising edge
// - rst          in   1              reset
// - data_write   in   DATA_WIDTH     word to push
// - write        in   1              push request
// - full         out  1              count == NUM_SLOTS
// - almost_full  out  1              count >= NUM_SLOTS-1
// - data_read    out  DATA_WIDTH     head word (FWFT)
// - next_read    in   1              pop request
// - empty        out  1              count == 0
// BEHAVIOUR
// - Reset interface (already decided): one clock; reset is synchronous and active-high.
// - Reset effects: wr_ptr=0, rd_ptr=0, count=0, so empty=1, full=0, almost_full=0,
//   data_read=0. The storage array is not reset.
// - Reset mid-operation discards all contents.
// - Reset has priority over write and next_read.
// - State: mem[NUM_SLOTS], wr_ptr, rd_ptr (LOG_NUM_SLOTS bits), count (LOG_NUM_SLOTS+1 bits).
// - Flags: decoded combinationally from the registered count only; they have no
//   combinational dependence on write or next_read.
// - Push accepted: write & ~full. mem[wr_ptr] <= data_write; wr_ptr advances.
// - Push while full: silently dropped. No state change, no error flag.
// - Pop accepted: next_read & ~empty. rd_ptr advances.
// - Pop while empty: ignored.
// - Pointer wrap: a pointer at NUM_SLOTS-1 wraps explicitly to 0, so non-power-of-two depths work.
// - count update:
//   - +1 on push only
//   - -1 on pop only
//   - unchanged when both are accepted in the same cycle
// - Simultaneous events:
//   - Empty + write + next_read: push accepted, pop ignored. There is no bypass, so
//     empty falls at the next edge.
//   - Full + write + next_read: pop accepted, push dropped, because acceptance uses
//     the registered full flag.
//   - Partially filled + both: both accepted; count unchanged; order preserved.
// - data_read = empty ? 0 : mem[rd_ptr]. Combinational from registers.
// - Write latency: a word pushed at edge t is visible on data_read, with empty=0,
//   in the cycle after edge t.
// - Ordering: strict FIFO. No word is lost or duplicated except pushes dropped while full.
// - Integrity: count never exceeds NUM_SLOTS and never goes below 0.
// STRUCTURE
// - Single flat module; no sub-modules.
// - Memory: a register array, not inferred BRAM, because the output is read asynchronously.
// - Shared package: none required; the pointer-increment-with-wrap helper may live locally.
// - Elaboration checks (generate/initial): NUM_SLOTS >= 2 and
//   2**LOG_NUM_SLOTS >= NUM_SLOTS; fail at elaboration otherwise.
// - Simulation-only assertions:
//   - count <= NUM_SLOTS
//   - empty and full are never both high
// TESTING
// - Reset: after rst=1 for 2 cycles -> empty=1, full=0, almost_full=0, data_read=0.
// - Fill and drain, NUM_SLOTS=4: push 0x11,0x22,0x33.
//   -> After the third push: almost_full=1, full=0.
//   -> Push 0x44: full=1.
//   -> Pop 4 times: data_read shows 0x11,0x22,0x33,0x44 in turn, then empty=1.
// - Overflow: with the FIFO full, push 0x55 -> dropped. Four pops return 0x11..0x44 only.
// - Underflow: next_read while empty -> no change; a later push 0xAA then pop returns 0xAA.
// - Simultaneous ops:
//   -> Holding 2 words, write+next_read for 10 cycles with incrementing data: count stays 2,
//      ordering correct across pointer wrap.
//   -> Full + both asserted: count drops to 3 and the pushed word is dropped.
// - Mid-operation reset: with 3 words stored, assert rst -> empty=1 next cycle; a new
//   push 0x77 then pop returns 0x77.

Source files
------------

// File: rtl/fifo_buffer_pkg.sv
// Shared defaults for the stream input buffer.
// Other blocks that embed a fifo_buffer can pull matching sizes from here,
// so the buffer and its users agree on word width and depth.
package fifo_buffer_pkg;
  localparam int DEF_NUM_SLOTS     = 4;
  localparam int DEF_LOG_NUM_SLOTS = 2;
  localparam int DEF_DATA_WIDTH    = 8;
endpackage : fifo_buffer_pkg

// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous first-word-fall-through FIFO.
// This is the input buffer of stream modules. It decouples a valid-only producer
// from a downstream consumer. The head word is always visible on data_read.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears pointers and count)
//   data_write   word to push
//   write        push request (dropped when full)
//   full         count == NUM_SLOTS
//   almost_full  count >= NUM_SLOTS-1
//   data_read    head word, 0 while empty
//   next_read    pop request (ignored when empty)
//   empty        count == 0
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int NUM_SLOTS     = DEF_NUM_SLOTS,
  parameter int LOG_NUM_SLOTS = DEF_LOG_NUM_SLOTS,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  if (NUM_SLOTS < 2 || (2 ** LOG_NUM_SLOTS) < NUM_SLOTS) begin : g_bad_params
    $error("fifo_buffer: need NUM_SLOTS >= 2 and 2**LOG_NUM_SLOTS >= NUM_SLOTS");
  end

  localparam logic [LOG_NUM_SLOTS:0]   FULL_CNT = NUM_SLOTS[LOG_NUM_SLOTS:0];
  localparam logic [LOG_NUM_SLOTS:0]   AF_CNT   = FULL_CNT - 1'b1;
  localparam logic [LOG_NUM_SLOTS-1:0] LAST_PTR = LOG_NUM_SLOTS'(NUM_SLOTS - 1);

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [LOG_NUM_SLOTS-1:0] ptr_inc(input logic [LOG_NUM_SLOTS-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_NUM_SLOTS:0]   count_q, count_d;
  logic                     push, pop;

  // The flags depend only on the registered count. So a push into a full FIFO is
  // dropped even when a pop is accepted in the same cycle. Likewise a pop from an
  // empty FIFO is ignored even when a push arrives in the same cycle. There is no bypass.
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign data_read   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push     = write && !full;
    pop      = next_read && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage is not reset. Only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= data_write;
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) count_q <= FULL_CNT)
    else $error("fifo_buffer: count exceeds NUM_SLOTS");
  a_flags_excl:  assert property (@(posedge clk) !(empty && full))
    else $error("fifo_buffer: empty and full both high");
`endif

endmodule : fifo_buffer

// File: tb/tb_fifo_buffer.sv
module tb_fifo_buffer;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_write = '0;
  logic          write = 1'b0;
  logic          next_read = 1'b0;
  logic          full, almost_full, empty;
  logic [DW-1:0] data_read;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] exp_q[$];

  fifo_buffer #(.NUM_SLOTS(N), .LOG_NUM_SLOTS(2), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .data_write(data_write), .write(write),
    .full(full), .almost_full(almost_full), .data_read(data_read),
    .next_read(next_read), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of words. Acceptance is decided from the
  // occupancy before the edge. Pushed words are the expected outputs.
  always @(posedge clk) begin
    bit pu, po;
    if (rst) exp_q.delete();
    else begin
      pu = write && (exp_q.size() < N);
      po = next_read && (exp_q.size() > 0);
      if (po) void'(exp_q.pop_front());
      if (pu) exp_q.push_back(data_write);
    end
  end

  // Monitor: compares the DUT against the model on every falling edge.
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = exp_q.size();
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == N));
      chk("almost_full", 32'(almost_full), 32'(n >= N - 1));
      chk("data_read", 32'(data_read), (n == 0) ? 32'd0 : 32'(exp_q[0]));
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    write = w; data_write = d; next_read = r;
    @(posedge clk); #1;
    write = 1'b0; next_read = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_data", 32'(data_read), 32'd0);

    // Fill, overflow, drain
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    chk("fill3_af", 32'(almost_full), 32'd1);
    chk("fill3_full", 32'(full), 32'd0);
    cyc(1, 8'h44, 0);
    chk("fill4_full", 32'(full), 32'd1);
    cyc(1, 8'h55, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_head", 32'(data_read), 32'h11);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(data_read), 32'(8'h11 * (i + 1)));
      cyc(0, 8'h00, 1);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 1);
    chk("udf_empty", 32'(empty), 32'd1);
    cyc(1, 8'hAA, 0);
    chk("udf_head", 32'(data_read), 32'hAA);
    cyc(0, 8'h00, 1);
    chk("udf_empty2", 32'(empty), 32'd1);

    // Empty + both: push accepted, pop ignored
    cyc(1, 8'h5A, 1);
    chk("emp_both_head", 32'(data_read), 32'h5A);
    cyc(0, 8'h00, 1);

    // Two words held, simultaneous push/pop across pointer wrap
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h03 + i), 1);
    chk("sim_af", 32'(almost_full), 32'd0);
    chk("sim_head", 32'(data_read), 32'h0B);
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 1);
    chk("sim_empty", 32'(empty), 32'd1);

    // Full + both: pop accepted, push dropped
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), 0);
    cyc(1, 8'hEE, 1);
    chk("fb_full", 32'(full), 32'd0);
    chk("fb_af", 32'(almost_full), 32'd1);
    chk("fb_head", 32'(data_read), 32'hC1);
    repeat (3) cyc(0, 8'h00, 1);
    chk("fb_empty", 32'(empty), 32'd1);

    // Mid-operation reset
    cyc(1, 8'h31, 0); cyc(1, 8'h32, 0); cyc(1, 8'h33, 0);
    rst = 1'b1; cyc(1, 8'h99, 1); rst = 1'b0;
    chk("mrst_empty", 32'(empty), 32'd1);
    cyc(1, 8'h77, 0);
    chk("mrst_head", 32'(data_read), 32'h77);
    cyc(0, 8'h00, 1);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50));
      rst = 1'b0;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule : tb_fifo_buffer
